// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate modes,
// a one-cycle wrap pulse, a divided-clock output and a sticky saturation flag.
module mod_counter #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned MAX       = (2 ** WIDTH) - 1,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             clk_out,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_V   = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_V = RESET_VAL[WIDTH-1:0];

    // Loaded values above the terminal value are pulled back to MAX so the
    // count can never leave 0..MAX.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= RESET_V;
            wrap    <= 1'b0;
            clk_out <= 1'b0;
            sat     <= 1'b0;
        end else if (load) begin
            count <= clamp_load(load_val);
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else if (en) begin
            if (up_dn) begin
                // Terminal detect compares against MAX, not natural overflow.
                if (count == MAX_V) begin
                    if (SATURATE) begin
                        wrap <= 1'b0;
                        sat  <= 1'b1;
                    end else begin
                        count   <= '0;
                        wrap    <= 1'b1;
                        clk_out <= ~clk_out;
                    end
                end else begin
                    count <= count + 1'b1;
                    wrap  <= 1'b0;
                end
            end else begin
                if (count == '0) begin
                    if (SATURATE) begin
                        wrap <= 1'b0;
                        sat  <= 1'b1;
                    end else begin
                        count   <= MAX_V;
                        wrap    <= 1'b1;
                        clk_out <= ~clk_out;
                    end
                end else begin
                    count <= count - 1'b1;
                    wrap  <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: default wrap counter, MAX=5 wrap counter
// and a saturating counter with non-zero reset value.
module tb_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults (WIDTH=3, MAX=7, wrap, RESET_VAL=0)
    logic       a_rst, a_en, a_up, a_ld;
    logic [2:0] a_lv, a_cnt;
    logic       a_wrap, a_clko, a_sat;

    // Instance B: MAX=5, wrap
    logic       b_rst, b_en, b_up, b_ld;
    logic [2:0] b_lv, b_cnt;
    logic       b_wrap, b_clko, b_sat;

    // Instance C: MAX=7, saturate, RESET_VAL=3
    logic       c_rst, c_en, c_up, c_ld;
    logic [2:0] c_lv, c_cnt;
    logic       c_wrap, c_clko, c_sat;

    mod_counter dut_a (
        .clk(clk), .reset(a_rst), .en(a_en), .up_dn(a_up), .load(a_ld),
        .load_val(a_lv), .count(a_cnt), .wrap(a_wrap), .clk_out(a_clko), .sat(a_sat)
    );

    mod_counter #(.WIDTH(3), .MAX(5), .SATURATE(1'b0), .RESET_VAL(0)) dut_b (
        .clk(clk), .reset(b_rst), .en(b_en), .up_dn(b_up), .load(b_ld),
        .load_val(b_lv), .count(b_cnt), .wrap(b_wrap), .clk_out(b_clko), .sat(b_sat)
    );

    mod_counter #(.WIDTH(3), .MAX(7), .SATURATE(1'b1), .RESET_VAL(3)) dut_c (
        .clk(clk), .reset(c_rst), .en(c_en), .up_dn(c_up), .load(c_ld),
        .load_val(c_lv), .count(c_cnt), .wrap(c_wrap), .clk_out(c_clko), .sat(c_sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int cnt, input int wr, input int co);
        chk({tag, " A.count"}, 32'(a_cnt), cnt);
        chk({tag, " A.wrap"}, 32'(a_wrap), wr);
        chk({tag, " A.clk_out"}, 32'(a_clko), co);
    endtask

    task automatic chk_b(input string tag, input int cnt, input int wr, input int co);
        chk({tag, " B.count"}, 32'(b_cnt), cnt);
        chk({tag, " B.wrap"}, 32'(b_wrap), wr);
        chk({tag, " B.clk_out"}, 32'(b_clko), co);
    endtask

    task automatic chk_c(input string tag, input int cnt, input int wr, input int st);
        chk({tag, " C.count"}, 32'(c_cnt), cnt);
        chk({tag, " C.wrap"}, 32'(c_wrap), wr);
        chk({tag, " C.sat"}, 32'(c_sat), st);
    endtask

    // en-toggle table for instance A: en, up_dn, expected count/wrap/clk_out
    localparam int NT = 10;
    logic t_en [NT] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic t_up [NT] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int   t_cnt[NT] = '{1, 1, 2, 2, 1, 1, 0, 0, 7, 7};
    int   t_wr [NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int   t_co [NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        a_rst = 1; a_en = 0; a_up = 1; a_ld = 0; a_lv = '0;
        b_rst = 1; b_en = 0; b_up = 0; b_ld = 0; b_lv = '0;
        c_rst = 1; c_en = 0; c_up = 1; c_ld = 0; c_lv = '0;
        step();
        chk_a("reset", 0, 0, 0);
        chk("reset A.sat", 32'(a_sat), 0);
        chk_b("reset", 0, 0, 0);
        chk_c("reset", 3, 0, 0);
        chk("reset C.clk_out", 32'(c_clko), 0);

        // ---- A: full up-count, two wraps
        a_rst = 0; a_en = 1; a_up = 1;
        for (int i = 1; i <= 7; i++) begin step(); chk_a("up1", i, 0, 0); end
        step(); chk_a("wrap1", 0, 1, 1);
        for (int i = 1; i <= 7; i++) begin step(); chk_a("up2", i, 0, 1); end
        step(); chk_a("wrap2", 0, 1, 0);

        // ---- A: reach count=4 with clk_out=1, then reset with load asserted
        for (int i = 1; i <= 8; i++) step();
        chk_a("wrap3", 0, 1, 1);
        for (int i = 1; i <= 4; i++) step();
        chk_a("pre-reset", 4, 0, 1);
        a_rst = 1; a_ld = 1; a_lv = 3'd6;
        step(); chk_a("mid-reset", 0, 0, 0);
        chk("mid-reset A.sat", 32'(a_sat), 0);

        // ---- A: en toggling with direction flip
        a_rst = 0; a_ld = 0;
        for (int i = 0; i < NT; i++) begin
            a_en = t_en[i]; a_up = t_up[i];
            step(); chk_a($sformatf("entog%0d", i), t_cnt[i], t_wr[i], t_co[i]);
        end

        // ---- B: MAX=5 down-count from 0
        b_rst = 0; b_en = 1; b_up = 0;
        step(); chk_b("dn wrap1", 5, 1, 1);
        for (int i = 4; i >= 0; i--) begin step(); chk_b("dn", i, 0, 1); end
        step(); chk_b("dn wrap2", 5, 1, 0);

        // ---- B: load clamp and load priority over en
        b_ld = 1; b_lv = 3'd7;
        step(); chk_b("clamp", 5, 0, 0);
        b_lv = 3'd3;
        step(); chk_b("load>en", 3, 0, 0);
        b_ld = 0; b_up = 1;
        step(); chk_b("up", 4, 0, 0);
        step(); chk_b("up", 5, 0, 0);
        step(); chk_b("up wrap", 0, 1, 1);
        b_en = 0;
        step(); chk_b("hold", 0, 0, 1);

        // ---- C: saturate high, sticky sat, load clears
        c_rst = 0; c_ld = 1; c_lv = 3'd6;
        step(); chk_c("load6", 6, 0, 0);
        c_ld = 0; c_en = 1; c_up = 1;
        step(); chk_c("to7", 7, 0, 0);
        step(); chk_c("hold7a", 7, 0, 1);
        step(); chk_c("hold7b", 7, 0, 1);
        c_en = 0;
        step(); chk_c("idle", 7, 0, 1);
        c_ld = 1; c_lv = 3'd2;
        step(); chk_c("load2", 2, 0, 0);

        // ---- C: saturate low, then count up with sat still set
        c_ld = 0; c_en = 1; c_up = 0;
        step(); chk_c("dn1", 1, 0, 0);
        step(); chk_c("dn0", 0, 0, 0);
        step(); chk_c("hold0", 0, 0, 1);
        chk("hold0 C.clk_out", 32'(c_clko), 0);
        c_up = 1;
        for (int i = 1; i <= 4; i++) begin step(); chk_c("up sticky", i, 0, 1); end

        // ---- C: reset at count=4, sat=1, load asserted
        c_rst = 1; c_ld = 1; c_lv = 3'd6;
        step(); chk_c("mid-reset", 3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
